// File: rtl/freq_meas_sequencer.sv
// freq_meas_sequencer: time-shares one frequency counter across N_CH channels.
// Steps through enabled channels: steer mux, settle, clear, gate, capture result.
// Ports:
//   Clock, Reset       rising-edge clock, synchronous active-high reset
//   start, ch_mask     sweep request and channel enables (sampled when idle)
//   busy, done         sweep in progress / one-cycle end-of-sweep pulse
//   ctr_sel/clear/gate counter control: mux select, clear pulse, count enable
//   ctr_value, ctr_ovf counter result and wrap flag
//   rd_addr, rd_data   registered result buffer read port (1-cycle latency)
//   rd_valid, rd_ovf   per-slot written / overflowed flags
module freq_meas_sequencer #(
  parameter int N_CH          = 8,
  parameter int CNT_W         = 16,
  parameter int GATE_CYCLES   = 1000,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    start,
  input  logic [N_CH-1:0]         ch_mask,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(N_CH)-1:0] ctr_sel,
  output logic                    ctr_clear,
  output logic                    ctr_gate,
  input  logic [CNT_W-1:0]        ctr_value,
  input  logic                    ctr_ovf,
  input  logic [$clog2(N_CH)-1:0] rd_addr,
  output logic [CNT_W-1:0]        rd_data,
  output logic [N_CH-1:0]         rd_valid,
  output logic [N_CH-1:0]         rd_ovf
);

  localparam int SEL_W = $clog2(N_CH);
  localparam int CMAX  = (GATE_CYCLES > SETTLE_CYCLES) ?
                         GATE_CYCLES : SETTLE_CYCLES;
  localparam int CW    = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE, SEEK, SETTLE, CLEAR, GATE, CAPTURE, FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [N_CH-1:0]   pend_q, pend_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SEL_W-1:0]  low_idx;
  logic              wr_en;
  logic              sweep_go;
  logic [CNT_W-1:0]  mem [N_CH];
  logic [N_CH-1:0]   valid_q, ovf_q;

  always_comb begin
    low_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pend_q[i]) low_idx = SEL_W'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    wr_en     = 1'b0;
    sweep_go  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    ctr_clear = 1'b0;
    ctr_gate  = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          sweep_go = 1'b1;
          pend_d   = ch_mask;
          state_d  = SEEK;
        end
      end
      SEEK: begin
        cnt_d = '0;
        if (pend_q == '0) begin
          state_d = FINISH;
        end else begin
          sel_d           = low_idx;
          pend_d[low_idx] = 1'b0;
          state_d         = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = CLEAR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CLEAR: begin
        ctr_clear = 1'b1;
        cnt_d     = '0;
        state_d   = GATE;
      end
      GATE: begin
        ctr_gate = 1'b1;
        if (cnt_q == CW'(GATE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CAPTURE: begin
        if (cnt_q == CW'(1)) begin
          wr_en = 1'b1;
          cnt_d = '0;
          // Nothing left to seek: skip the empty SEEK visit.
          state_d = (pend_q == '0) ? FINISH : SEEK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FINISH: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      valid_q <= '0;
      ovf_q   <= '0;
      rd_data <= '0;
      for (int i = 0; i < N_CH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      rd_data <= mem[rd_addr];
      if (sweep_go) begin
        valid_q <= '0;
        ovf_q   <= '0;
      end
      if (wr_en) begin
        mem[sel_q]     <= ctr_ovf ? {CNT_W{1'b1}} : ctr_value;
        valid_q[sel_q] <= 1'b1;
        ovf_q[sel_q]   <= ctr_ovf;
      end
    end
  end

  assign ctr_sel  = sel_q;
  assign rd_valid = valid_q;
  assign rd_ovf   = ovf_q;

endmodule

// File: tb/tb_freq_meas_sequencer.sv
// tb_freq_meas_sequencer: directed + randomized sweeps against a counter model.
// Expected results come from channel periods: slot = GATE / period, or all-ones.
module tb_freq_meas_sequencer;

  localparam int N   = 8;
  localparam int G   = 1000;
  localparam int S   = 4;
  localparam int PER = 1 + S + 1 + G + 2;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  ch_mask = '0;
  logic        busy, done;
  logic [2:0]  ctr_sel;
  logic        ctr_clear, ctr_gate;
  logic [15:0] ctr_value;
  logic        ctr_ovf;
  logic [2:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic [7:0]  rd_valid, rd_ovf;

  freq_meas_sequencer #(
    .N_CH(N), .CNT_W(16), .GATE_CYCLES(G), .SETTLE_CYCLES(S)
  ) dut (
    .Clock(Clock), .Reset(Reset), .start(start), .ch_mask(ch_mask),
    .busy(busy), .done(done), .ctr_sel(ctr_sel),
    .ctr_clear(ctr_clear), .ctr_gate(ctr_gate),
    .ctr_value(ctr_value), .ctr_ovf(ctr_ovf),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ovf(rd_ovf)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Input waveforms: channel c has one edge every period[c] clocks.
  int          period [N] = '{default: 10};
  int          ph [N] = '{default: 0};
  logic [15:0] cnt = '0;
  logic [7:0]  ovf_force = '0;

  always @(posedge Clock) begin
    for (int c = 0; c < N; c++)
      ph[c] <= (ph[c] >= period[c] - 1) ? 0 : ph[c] + 1;
    if (ctr_clear) cnt <= '0;
    else if (ctr_gate && ph[ctr_sel] == 0) cnt <= cnt + 16'd1;
  end
  assign ctr_value = cnt;
  assign ctr_ovf   = ovf_force[ctr_sel];

  int   gate_q [$];
  int   order_q [$];
  int   sel_glitch = 0;
  int   run = 0;
  logic pg = 1'b0;
  logic [2:0] ps = '0;
  int   done_seen = 0;
  int   done_cyc = 0;
  logic done_busy = 1'b0;

  always @(negedge Clock) begin
    if (ctr_clear) order_q.push_back(int'(ctr_sel));
    if (ctr_gate) begin
      if (pg && ctr_sel !== ps) sel_glitch++;
      run++;
    end else if (pg) begin
      gate_q.push_back(run);
      run = 0;
    end
    if (done) begin
      done_seen++;
      done_cyc  = cyc;
      done_busy = busy;
    end
    pg = ctr_gate;
    ps = ctr_sel;
  end

  logic [15:0] exp_mem [N] = '{default: 16'h0};
  logic [7:0]  exp_valid = '0;
  logic [7:0]  exp_ovf = '0;
  int          divs [10] = '{1, 2, 4, 5, 8, 10, 20, 25, 40, 50};

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_buffer(string tag);
    for (int i = 0; i < N; i++) begin
      rd_addr = 3'(i);
      tick();
      chk($sformatf("%s_slot%0d", tag, i), 32'(rd_data), 32'(exp_mem[i]));
    end
    chk({tag, "_valid"}, 32'(rd_valid), 32'(exp_valid));
    chk({tag, "_ovf"}, 32'(rd_ovf), 32'(exp_ovf));
  endtask

  task automatic sweep(input logic [7:0] m, input logic [7:0] of,
                       input bit redundant, input string tag);
    int st, n, exp_done, budget;
    int exp_order [$];
    gate_q.delete();
    order_q.delete();
    sel_glitch = 0;
    done_seen  = 0;
    ovf_force  = of;
    ch_mask    = m;
    start      = 1'b1;
    st         = cyc;
    tick();
    start   = 1'b0;
    ch_mask = 8'($urandom);
    @(negedge Clock);
    chk({tag, "_busy_seek"}, 32'(busy), 32'd1);
    if (redundant) begin
      tick();
      start   = 1'b1;
      ch_mask = ~m;
      tick();
      start   = 1'b0;
    end
    n        = $countones(m);
    exp_done = (n == 0) ? st + 2 : st + 1 + n * PER;
    budget   = n * PER + 50;
    for (int i = 0; i < budget && done_seen == 0; i++) @(negedge Clock);
    repeat (3) @(negedge Clock);
    chk({tag, "_done_pulses"}, 32'(done_seen), 32'd1);
    chk({tag, "_done_cycle"}, 32'(done_cyc - st), 32'(exp_done - st));
    chk({tag, "_busy_at_done"}, 32'(done_busy), 32'd0);
    for (int c = 0; c < N; c++) begin
      if (m[c]) begin
        exp_mem[c] = of[c] ? 16'hFFFF : 16'(G / period[c]);
        exp_order.push_back(c);
      end
    end
    exp_valid = m;
    exp_ovf   = m & of;
    chk({tag, "_visits"}, 32'(order_q.size()), 32'(n));
    for (int i = 0; i < n && i < order_q.size(); i++)
      chk($sformatf("%s_order%0d", tag, i), 32'(order_q[i]),
          32'(exp_order[i]));
    chk({tag, "_windows"}, 32'(gate_q.size()), 32'(n));
    foreach (gate_q[i])
      chk($sformatf("%s_gate_len%0d", tag, i), 32'(gate_q[i]), 32'(G));
    chk({tag, "_sel_stable"}, 32'(sel_glitch), 32'd0);
    check_buffer(tag);
  endtask

  initial begin
    bit found;
    logic [7:0] m, of;
    repeat (3) tick();
    Reset = 1'b0;
    tick();
    @(negedge Clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sel", 32'(ctr_sel), 32'd0);
    chk("rst_clear", 32'(ctr_clear), 32'd0);
    chk("rst_gate", 32'(ctr_gate), 32'd0);
    check_buffer("rst");

    period[0] = 10;
    sweep(8'h01, 8'h00, 1'b0, "single");

    period[0] = 10; period[2] = 20; period[5] = 40; period[7] = 50;
    sweep(8'hA5, 8'h00, 1'b1, "multi");

    sweep(8'h00, 8'h00, 1'b0, "empty");

    period[3] = 8;
    sweep(8'h09, 8'h08, 1'b0, "ovf");
    sweep(8'h08, 8'h00, 1'b0, "ovf_clr");

    repeat (3) begin
      for (int c = 0; c < N; c++) period[c] = divs[$urandom_range(0, 9)];
      m  = 8'($urandom_range(1, 255));
      of = 8'($urandom) & 8'($urandom);
      sweep(m, of, 1'b1, "rand");
    end

    period[1] = 5; period[2] = 4;
    ovf_force = '0;
    ch_mask   = 8'h06;
    start     = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3 * PER && !found; i++) begin
      @(negedge Clock);
      if (ctr_gate && ctr_sel == 3'd2) found = 1'b1;
    end
    chk("abort_reach_gate", 32'(found), 32'd1);
    repeat (100) @(negedge Clock);
    done_seen = 0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    @(negedge Clock);
    chk("abort_gate", 32'(ctr_gate), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sel", 32'(ctr_sel), 32'd0);
    repeat (20) @(negedge Clock);
    chk("abort_no_done", 32'(done_seen), 32'd0);
    for (int c = 0; c < N; c++) exp_mem[c] = '0;
    exp_valid = '0;
    exp_ovf   = '0;
    check_buffer("abort");

    sweep(8'h04, 8'h00, 1'b0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
